rr_arb4_mux: RTL and testbench
==============================

RR_ARB4_MUX -- requirements
Module: rr_arb4_mux

Interface
REQ-001 Parameter: W, default 8, width of each requester data word and of the output word.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  req[i] high: requester i has a word on d[i].
REQ-005 d  input  4*W  requester data; d[i] occupies bits [i*W+W-1 : i*W].
REQ-006 ack  output  4  one-hot pulse; ack[i] high for one cycle when d[i] is captured.
REQ-007 out_data  output  W  registered captured word.
REQ-008 out_valid  output  1  out_data holds a word not yet accepted.
REQ-009 out_ready  input  1  downstream accepts out_data when out_valid and out_ready are both high.
REQ-010 out_sel  output  2  registered index of the requester whose word is in out_data.

Function
REQ-011 The block SHALL implement two states: IDLE (out_valid=0) and HOLD (out_valid=1).
REQ-012 A capture opportunity SHALL exist in a cycle where state is IDLE, or state is HOLD and out_valid & out_ready.
REQ-013 At a capture opportunity with req!=0, the winner SHALL be the first requester with req set, searching from (last+1) mod 4 upward with wrap-around, where last is the 2-bit index of the most recent winner.
REQ-014 On capture, at the clock edge: out_data<=d[winner], out_sel<=winner, last<=winner, state<=HOLD.
REQ-015 ack[winner] SHALL be driven combinationally high in the capture cycle only; ack SHALL be 0 in all other cycles.
REQ-016 At a capture opportunity with req==0: state<=IDLE, out_valid deasserts next cycle, out_data and out_sel hold their values.
REQ-017 In HOLD without out_ready, out_data, out_sel and last SHALL remain stable, and ack SHALL be 0.
REQ-018 Back-to-back: transfer and new capture in the same cycle SHALL give out_valid continuously high; sustained throughput is 1 word/cycle.
REQ-019 Latency: req asserted in IDLE at cycle n produces ack in cycle n and out_valid=1 with the word from cycle n+1.
REQ-020 A requester keeping req high after ack SHALL be treated as presenting a new word; it competes with lowest priority in the next arbitration.
REQ-021 Changes on req or d outside a capture cycle SHALL NOT affect out_data.
REQ-022 Fairness: with all four req held high, winners SHALL cycle 0,1,2,3,0,... starting from last+1.
REQ-023 out_data mux SHALL select d[winner] using the 2-bit winner index as the select of a 4:1 word multiplexer.

Reset
REQ-024 On rst_n low, immediately and independent of clk: state=IDLE, out_valid=0, out_data=0, out_sel=0, last=3, ack=0.
REQ-025 last=3 after reset SHALL give requester 0 highest priority at the first arbitration.
REQ-026 Reset asserted while in HOLD SHALL discard the held word with no transfer; no ack SHALL issue while rst_n is low.
REQ-027 On rst_n release, the first capture SHALL be possible on the first rising edge at which rst_n is high.

Verification
REQ-028 Reset, then req=4'b1111 with d[i]=8'h10+i and out_ready=1 -> ack sequence 0001,0010,0100,1000,0001; out_data 10,11,12,13,10 on consecutive cycles; out_valid stays 1.
REQ-029 Capture d[2]=8'hA5 with out_ready=0 for 5 cycles while d[2] changes to 8'h3C -> out_data=A5 and out_valid=1 throughout; ack=0; transfer occurs in the cycle out_ready rises.
REQ-030 last=1, req=4'b0001 -> winner 0 via wrap-around; out_sel=0.
REQ-031 Single requester 3 holds req high, out_ready=1 -> ack[3] every cycle, out_sel=3 continuously.
REQ-032 req drops to 0 at a transfer -> out_valid=0 next cycle, out_data holds its last value; a new req one cycle later is captured from IDLE.
REQ-033 rst_n pulsed low mid-HOLD between clock edges -> out_valid=0 and out_data=0 before the next edge; the next arbitration starts at requester 0.

Source files
------------

// File: rtl/rr_arb4_mux.sv
// Four-requester round-robin arbiter feeding a single registered output word.
// A winner is captured whenever the output slot is empty or is drained this cycle.
module rr_arb4_mux #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] d,
    output logic [3:0]     ack,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [1:0]     out_sel
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     last_q, last_d;
    logic [W-1:0]   data_q, data_d;
    logic [1:0]     sel_q, sel_d;
    logic [3:0]     ack_s;
    logic [2:0]     pick_s;
    logic           cap_s;
    logic [W-1:0]   word_s;

    // Returns {found, index}; scanning offsets 4 down to 1 lets the smallest
    // offset from last (i.e. last+1) override, so last itself ranks lowest.
    function automatic logic [2:0] rr_pick(input logic [3:0] req_v, input logic [1:0] last_v);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            cand = last_v + 2'(k);
            if (req_v[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    function automatic logic [W-1:0] word_mux(input logic [4*W-1:0] d_v, input logic [1:0] sel_v);
        logic [W-1:0] res;
        case (sel_v)
            2'd0:    res = d_v[0*W +: W];
            2'd1:    res = d_v[1*W +: W];
            2'd2:    res = d_v[2*W +: W];
            2'd3:    res = d_v[3*W +: W];
            default: res = {W{1'b0}};
        endcase
        return res;
    endfunction

    assign pick_s = rr_pick(req, last_q);
    assign word_s = word_mux(d, pick_s[1:0]);
    assign cap_s  = (state_q == IDLE) || out_ready;

    // Next-state logic: capture the winner at an opportunity, otherwise hold.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        data_d  = data_q;
        sel_d   = sel_q;
        ack_s   = 4'b0000;
        if (cap_s) begin
            if (pick_s[2]) begin
                state_d = HOLD;
                last_d  = pick_s[1:0];
                data_d  = word_s;
                sel_d   = pick_s[1:0];
                ack_s   = 4'b0001 << pick_s[1:0];
            end else begin
                state_d = IDLE;
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and output-word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            data_q  <= {W{1'b0}};
            sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    // ack is combinational, so it must be masked while reset is held.
    assign ack       = ack_s & {4{rst_n}};
    assign out_data  = data_q;
    assign out_sel   = sel_q;
    assign out_valid = (state_q == HOLD);

endmodule

// File: tb/tb_rr_arb4_mux.sv
// Scoreboard bench for rr_arb4_mux: stimulus pushes expected acks and words,
// a negedge monitor pops and compares whenever the DUT acks or transfers.
module tb_rr_arb4_mux;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] d;
    logic [3:0]  ack;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_sel;

    int total = 0;
    int bad   = 0;

    logic [3:0] ack_q[$];
    logic [9:0] exp_q[$];

    rr_arb4_mux #(.W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .d         (d),
        .ack       (ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cap(input logic [3:0] a, input logic [7:0] dat, input logic [1:0] sel);
        ack_q.push_back(a);
        exp_q.push_back({sel, dat});
    endtask

    // Monitor: every ack and every transfer must match the head of its queue.
    always @(negedge clk) begin
        logic [3:0] ea;
        logic [9:0] ew;
        if (rst_n) begin
            if (ack != 4'b0000) begin
                if (ack_q.size() == 0) begin
                    chk("ack_unexpected", {28'd0, ack}, 32'd0);
                end else begin
                    ea = ack_q.pop_front();
                    chk("ack", {28'd0, ack}, {28'd0, ea});
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("xfer_unexpected", {22'd0, out_sel, out_data}, 32'd0);
                end else begin
                    ew = exp_q.pop_front();
                    chk("xfer_data", {24'd0, out_data}, {24'd0, ew[7:0]});
                    chk("xfer_sel", {30'd0, out_sel}, {30'd0, ew[9:8]});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req = 4'hF;
        d = 32'd0;
        out_ready = 1'b0;
        #7;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_sel", {30'd0, out_sel}, 32'd0);
        chk("rst_ack", {28'd0, ack}, 32'd0);

        // Fairness with all four requesting: 0,1,2,3,0.
        step();
        rst_n = 1'b1;
        d = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'hF;
        out_ready = 1'b1;
        expect_cap(4'b0001, 8'h10, 2'd0);
        expect_cap(4'b0010, 8'h11, 2'd1);
        expect_cap(4'b0100, 8'h12, 2'd2);
        expect_cap(4'b1000, 8'h13, 2'd3);
        expect_cap(4'b0001, 8'h10, 2'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i > 0) chk("b2b_valid", {31'd0, out_valid}, 32'd1);
            step();
        end
        req = 4'h0;
        @(negedge clk);
        chk("last_xfer_valid", {31'd0, out_valid}, 32'd1);
        step();
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_hold_data", {24'd0, out_data}, 32'h10);
        chk("idle_hold_sel", {30'd0, out_sel}, 32'd0);

        // Stall in HOLD while the captured requester's word changes.
        req = 4'b0100;
        d[23:16] = 8'hA5;
        out_ready = 1'b0;
        expect_cap(4'b0100, 8'hA5, 2'd2);
        step();
        for (int i = 0; i < 5; i++) begin
            d[23:16] = 8'h3C;
            chk("stall_data", {24'd0, out_data}, 32'hA5);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            step();
        end
        out_ready = 1'b1;
        req = 4'h0;
        step();
        chk("after_stall_valid", {31'd0, out_valid}, 32'd0);

        // last=2 picks 1, then last=1 wraps to 0, then requester 3 streams.
        req = 4'b0010;
        d[15:8] = 8'h55;
        expect_cap(4'b0010, 8'h55, 2'd1);
        step();
        req = 4'b0001;
        d[7:0] = 8'h66;
        expect_cap(4'b0001, 8'h66, 2'd0);
        step();
        chk("wrap_sel", {30'd0, out_sel}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            req = 4'b1000;
            d[31:24] = 8'h77 + 8'(k);
            expect_cap(4'b1000, 8'h77 + 8'(k), 2'd3);
            step();
            chk("single_sel", {30'd0, out_sel}, 32'd3);
        end
        req = 4'h0;
        step();
        chk("stream_end_valid", {31'd0, out_valid}, 32'd0);

        // Reset pulse mid-HOLD discards the held word.
        req = 4'b0010;
        d[15:8] = 8'h99;
        out_ready = 1'b0;
        ack_q.push_back(4'b0010);
        step();
        chk("pre_rst_data", {24'd0, out_data}, 32'h99);
        #1;
        rst_n = 1'b0;
        req = 4'hF;
        d = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_data", {24'd0, out_data}, 32'd0);
        chk("midrst_sel", {30'd0, out_sel}, 32'd0);
        chk("midrst_ack", {28'd0, ack}, 32'd0);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        expect_cap(4'b0001, 8'hC0, 2'd0);
        step();
        req = 4'h0;
        step();
        chk("post_rst_data", {24'd0, out_data}, 32'hC0);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("ack_q_empty", ack_q.size(), 32'd0);
        chk("exp_q_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
